// File: rtl/common_pkg.sv
// Shared cbus types: request/response payloads and their field enums.
// Used by every cbus master, slave and interconnect block.
package common;

  localparam int unsigned CBUS_ADDR_W = 32;
  localparam int unsigned CBUS_DATA_W = 64;
  localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

  // Bytes per beat: 1, 2, 4 or 8.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } mem_size_t;

  // Beats per burst, encoded as log2(beats).
  typedef enum logic [2:0] {
    MLEN1  = 3'd0,
    MLEN2  = 3'd1,
    MLEN4  = 3'd2,
    MLEN8  = 3'd3,
    MLEN16 = 3'd4
  } mem_len_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    mem_size_t              size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    mem_len_t               len;
    burst_t                 burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arb_select.sv
// Combinational winner search for the cbus arbiter: scans the valid vector
// starting at start_i and wrapping, returning the first valid index.
// Ports:
//   valid_i    - one request-valid bit per requester
//   start_i    - index the search begins at
//   found_c_o  - at least one requester is valid
//   winner_c_o - index of the first valid requester at or after start_i
module cbus_arb_select #(
  parameter  int unsigned NUM_INPUTS = 2,
  localparam int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid_i,
  input  logic [IDX_W-1:0]      start_i,
  output logic                  found_c_o,
  output logic [IDX_W-1:0]      winner_c_o
);

  // Wrapping first-hit scan; modulo keeps non-power-of-two counts in range.
  always_comb begin
    logic [IDX_W-1:0] sel;
    found_c_o  = 1'b0;
    winner_c_o = '0;
    sel        = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      sel = IDX_W'((32'(start_i) + k) % NUM_INPUTS);
      if (!found_c_o && valid_i[sel]) begin
        found_c_o  = 1'b1;
        winner_c_o = sel;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Arbitrates NUM_INPUTS cache-side cbus requesters onto one memory-side
// cbus. A grant takes one IDLE cycle; the owner keeps the bus until the
// memory side returns ready && last, then the arbiter spends one cycle in
// IDLE before the next grant.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low reset
//   ireqs  - per-requester requests (port 0 ICache, port 1 DCache)
//   iresps - per-requester responses, all-zero except for the owner
//   oreq   - request forwarded to memory (owner's request, else zero)
//   oresp  - response from memory
// Build option: define CBUS_ARB_ROUND_ROBIN_EN for round-robin priority
// (search starts after the previous owner); otherwise lowest index wins.
module cbus_arbiter
  import common::*;
#(
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned OWNER_W = $clog2(NUM_INPUTS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   start_ptr;
  logic [OWNER_W-1:0]   winner;
  logic                 found;
  logic [NUM_INPUTS-1:0] valid_vec;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_valid
    assign valid_vec[g] = ireqs[g].valid;
  end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [OWNER_W-1:0] last_owner_q, last_owner_d;

  assign last_owner_d = (state_q == IDLE && found) ? winner : last_owner_q;
  assign start_ptr    = (last_owner_q == OWNER_W'(NUM_INPUTS - 1)) ? '0
                                                                    : last_owner_q + OWNER_W'(1);

  // Previous owner, so the search begins one past it.
  always_ff @(posedge clk) begin
    if (!reset) last_owner_q <= '0;
    else        last_owner_q <= last_owner_d;
  end
`else
  assign start_ptr = '0;
`endif

  cbus_arb_select #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_select (
    .valid_i    (valid_vec),
    .start_i    (start_ptr),
    .found_c_o  (found),
    .winner_c_o (winner)
  );

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next state and bus steering; oresp is ignored while IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    oreq    = '0;
    iresps  = '{default: '0};
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          owner_d = winner;
        end
      end
      BUSY: begin
        oreq            = ireqs[owner_q];
        iresps[owner_q] = oresp;
        if (oresp.ready && oresp.last) state_d = IDLE;
      end
    endcase
  end

`ifndef SYNTHESIS
  // Owner must hold valid for the whole burst; the arbiter keeps the grant anyway.
  always_ff @(posedge clk) begin
    if (reset && state_q == BUSY && !ireqs[owner_q].valid)
      $warning("cbus_arbiter: owner %0d dropped valid before last beat", owner_q);
  end
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural arbiter model.
module tb_cbus_arbiter;
  import common::*;

  localparam int NI = 3;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [NI];
  cbus_resp_t iresps [NI];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_INPUTS(NI)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  // Behavioural model: who owns the bus (-1 = nobody), beats still owed.
  int m_owner    = -1;
  int m_last     = 0;
  int beats_left = 0;
  int done_cnt [NI];
  int grant_log[$];

  always @(posedge clk) begin
    int start;
    int idx;
    if (!reset) begin
      m_owner    = -1;
      m_last     = 0;
      beats_left = 0;
    end else if (m_owner < 0) begin
      start = RR ? (m_last + 1) % NI : 0;
      for (int k = 0; k < NI; k++) begin
        idx = (start + k) % NI;
        if (m_owner < 0 && ireqs[idx].valid) begin
          m_owner    = idx;
          m_last     = idx;
          beats_left = 1 << int'(ireqs[idx].len);
          grant_log.push_back(idx);
        end
      end
    end else if (oresp.ready) begin
      if (oresp.last) begin
        done_cnt[m_owner]++;
        m_owner = -1;
      end else begin
        beats_left--;
      end
    end
  end

  int  seen_cnt [NI];
  bit  mem_en    = 1'b0;
  bit  noise_en  = 1'b0;
  int  ready_pct = 100;
  bit  chk_en    = 1'b0;
  bit  sim_done  = 1'b0;
  int  gl0;
  cbus_req_t  exp_req;
  cbus_resp_t exp_resp;
  cbus_req_t  t30_req;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic cbus_req_t mk_req(input logic wr, input int sz, input logic [31:0] a,
                                       input logic [7:0] st, input logic [63:0] d,
                                       input int ln, input int bu);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = mem_size_t'(3'(sz));
    r.addr     = a;
    r.strobe   = st;
    r.data     = d;
    r.len      = mem_len_t'(3'(ln));
    r.burst    = burst_t'(2'(bu));
    return r;
  endfunction

  function automatic bit any_valid();
    bit v = 1'b0;
    for (int i = 0; i < NI; i++) v |= ireqs[i].valid;
    return v;
  endfunction

  // One clock: requesters whose burst finished drop valid; memory answers.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (done_cnt[i] != seen_cnt[i]) begin
        seen_cnt[i]    = done_cnt[i];
        ireqs[i].valid = 1'b0;
      end
    end
    if (mem_en && m_owner >= 0) begin
      oresp.ready = ($urandom_range(0, 99) < ready_pct);
      oresp.last  = oresp.ready && (beats_left == 1);
      oresp.data  = {$urandom, $urandom};
    end else if (mem_en && noise_en) begin
      oresp.ready = 1'($urandom_range(0, 1));
      oresp.last  = 1'($urandom_range(0, 1));
      oresp.data  = {$urandom, $urandom};
    end else begin
      oresp = '0;
    end
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while ((m_owner >= 0 || any_valid()) && n < budget) begin
      cycle();
      n++;
    end
    chk({name, "_budget"}, 128'(n < budget), 128'(1));
  endtask

  initial begin
    reset = 1'b0;
    oresp = '0;
    for (int i = 0; i < NI; i++) ireqs[i] = '0;
    fork
      begin : compare
        while (!sim_done) begin
          @(negedge clk);
          if (chk_en && !sim_done) begin
            exp_req = (m_owner < 0) ? '0 : ireqs[m_owner];
            chk("oreq", 128'(oreq), 128'(exp_req));
            for (int i = 0; i < NI; i++) begin
              exp_resp = (i == m_owner) ? oresp : '0;
              chk($sformatf("iresps%0d", i), 128'(iresps[i]), 128'(exp_resp));
            end
          end
        end
      end
      begin : stim
        repeat (3) cycle();
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_oreq", 128'(oreq), 128'(0));
        chk("rst_iresp1", 128'(iresps[1]), 128'(0));
        cycle();
        reset = 1'b1;

        // Single requester, 16-beat read burst.
        mem_en = 1'b1; ready_pct = 100; noise_en = 1'b0;
        gl0 = grant_log.size();
        ireqs[1] = mk_req(1'b0, 3, 32'h8000_0040, 8'hFF, 64'h0, 4, 1);
        @(negedge clk);
        chk("t27_wait", 128'(oreq.valid), 128'(0));
        cycle();
        @(negedge clk);
        chk("t27_grant_addr", 128'(oreq.addr), 128'(32'h8000_0040));
        for (int b = 1; b <= 16; b++) begin
          if (b > 1) begin
            cycle();
            @(negedge clk);
          end
          chk("t27_ready", 128'(iresps[1].ready), 128'(1));
          chk("t27_last", 128'(iresps[1].last), 128'(b == 16));
          chk("t27_p0", 128'(iresps[0]), 128'(0));
        end
        cycle();
        @(negedge clk);
        chk("t27_idle", 128'(oreq.valid), 128'(0));
        chk("t27_ngrants", 128'(grant_log.size() - gl0), 128'(1));

        // Ports 0 and 1 together: 0 first, one idle cycle, then 1.
        gl0 = grant_log.size();
        ireqs[0] = mk_req(1'b0, 3, 32'h0000_1000, 8'hFF, 64'h0, 2, 1);
        ireqs[1] = mk_req(1'b0, 3, 32'h0000_2000, 8'hFF, 64'h0, 0, 1);
        cycle();
        @(negedge clk);
        chk("t28_first_addr", 128'(oreq.addr), 128'(32'h0000_1000));
        repeat (4) cycle();
        @(negedge clk);
        chk("t28_gap", 128'(oreq.valid), 128'(0));
        cycle();
        @(negedge clk);
        chk("t28_second_addr", 128'(oreq.addr), 128'(32'h0000_2000));
        chk("t28_second_last", 128'(iresps[1].last), 128'(1));
        chk("t28_p0_quiet", 128'(iresps[0]), 128'(0));
        cycle();
        chk("t28_order0", 128'(grant_log[gl0]), 128'(0));
        chk("t28_order1", 128'(grant_log[gl0 + 1]), 128'(1));

        // Three rounds of simultaneous requests: 0,1,0,1,0,1.
        gl0 = grant_log.size();
        repeat (3) begin
          ireqs[0] = mk_req(1'b1, 3, 32'h0000_3000, 8'hFF, 64'h1, 1, 1);
          ireqs[1] = mk_req(1'b0, 3, 32'h0000_4000, 8'hFF, 64'h0, 1, 1);
          run_until_idle("t29", 40);
        end
        for (int k = 0; k < 6; k++)
          chk($sformatf("t29_order%0d", k), 128'(grant_log[gl0 + k]), 128'(k % 2));

        // Uncached single write with a stalled memory side.
        mem_en = 1'b0;
        t30_req = mk_req(1'b1, 2, 32'h1000_0000, 8'h0F, 64'hDEAD_BEEF_0123_4567, 0, 0);
        ireqs[1] = t30_req;
        cycle();
        @(negedge clk);
        chk("t30_oreq", 128'(oreq), 128'(t30_req));
        chk("t30_strobe", 128'(oreq.strobe), 128'(8'h0F));
        cycle();
        cycle();
        @(negedge clk);
        chk("t30_hold", 128'(oreq.valid), 128'(1));
        chk("t30_noready", 128'(iresps[1].ready), 128'(0));
        cycle();
        oresp = '{ready: 1'b1, last: 1'b1, data: 64'h55};
        @(negedge clk);
        chk("t30_beat", 128'(iresps[1]), 128'({1'b1, 1'b1, 64'h55}));
        cycle();
        @(negedge clk);
        chk("t30_idle", 128'(oreq.valid), 128'(0));

        // Port 0 waits while port 1 owns a stalled bus.
        gl0 = grant_log.size();
        ireqs[1] = mk_req(1'b0, 3, 32'h2000_0100, 8'hFF, 64'h0, 1, 1);
        cycle();
        ireqs[0] = mk_req(1'b0, 3, 32'h3000_0000, 8'hFF, 64'h0, 1, 1);
        repeat (10) begin
          cycle();
          @(negedge clk);
          chk("t32_p0_quiet", 128'(iresps[0]), 128'(0));
          chk("t32_owner", 128'(oreq.addr), 128'(32'h2000_0100));
        end
        mem_en = 1'b1;
        ready_pct = 100;
        run_until_idle("t32", 40);
        chk("t32_order0", 128'(grant_log[gl0]), 128'(1));
        chk("t32_order1", 128'(grant_log[gl0 + 1]), 128'(0));

        // Reset at beat 5 of a 16-beat burst.
        ireqs[1] = mk_req(1'b0, 3, 32'h5000_0000, 8'hFF, 64'h0, 4, 1);
        cycle();
        repeat (4) cycle();
        @(negedge clk);
        chk("t31_beat5", 128'(iresps[1].ready), 128'(1));
        reset = 1'b0;
        cycle();
        ireqs[1] = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("t31_idle", 128'(oreq.valid), 128'(0));
        chk("t31_iresp1", 128'(iresps[1]), 128'(0));
        ireqs[0] = mk_req(1'b0, 3, 32'h4000_0000, 8'hFF, 64'h0, 0, 1);
        cycle();
        @(negedge clk);
        chk("t31_regrant", 128'(oreq.addr), 128'(32'h4000_0000));
        run_until_idle("t31", 20);

        // Random traffic with stalls and idle-time response noise.
        ready_pct = 70;
        noise_en  = 1'b1;
        repeat (3000) begin
          cycle();
          for (int i = 0; i < NI; i++) begin
            if (!ireqs[i].valid && $urandom_range(0, 99) < 25)
              ireqs[i] = mk_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
                                8'($urandom), {$urandom, $urandom},
                                int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
          end
        end
        run_until_idle("drain", 400);
        @(negedge clk);
        sim_done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2: number of cache-side cbus requesters (ICache port 0, DCache port 1); legal range 2..8.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low; clock clk.
REQ-004 SHALL have port ireqs  input  NUM_INPUTS x cbus_req_t  per-requester bus requests.
REQ-005 SHALL have port iresps  output  NUM_INPUTS x cbus_resp_t  per-requester responses.
REQ-006 SHALL have port oreq  output  cbus_req_t  request to the memory side.
REQ-007 SHALL have port oresp  input  cbus_resp_t  response from the memory side.

Function
REQ-008 SHALL implement two states.
- IDLE: no owner.
- BUSY: one owner granted; owner index held in register owner.
REQ-009 In IDLE with at least one ireqs[i].valid, SHALL capture the winner into owner and enter BUSY at the next edge.
REQ-010 In IDLE, oreq SHALL be all-zero and every iresps[i] all-zero; the grant itself takes one cycle.
REQ-011 In BUSY, oreq SHALL equal ireqs[owner] combinationally, covering all fields (valid, is_write, size, addr, strobe, data, len, burst).
REQ-012 In BUSY, iresps[owner] SHALL equal oresp and every other iresps[i] SHALL be all-zero.
REQ-013 In BUSY, a cycle with oresp.ready && oresp.last SHALL return the arbiter to IDLE at the next edge; no same-cycle regrant.
REQ-014 The minimum gap between two grants SHALL therefore be one IDLE cycle.
REQ-015 Without round-robin, fixed priority SHALL apply: lowest-index valid requester wins.
REQ-016 Requesters not granted SHALL see ready=0 and last=0 and SHALL hold their request until granted; the arbiter keeps no request queue.
REQ-017 If ireqs[owner].valid drops while BUSY, the arbiter SHALL stay BUSY and forward valid=0 until oresp.last; this is a protocol violation and is flagged in simulation only.
REQ-018 oresp.ready in IDLE SHALL be ignored.
REQ-019 Simultaneous requests from all inputs SHALL produce exactly one grant.
REQ-020 owner width SHALL be $clog2(NUM_INPUTS).

Reset
REQ-021 While reset==0 at a clock edge, the next state SHALL be IDLE, owner 0, and the round-robin pointer 0.
REQ-022 After reset, oreq and all iresps SHALL be zero from the first cycle; a reset during BUSY abandons the burst.

Configuration
REQ-023 Macro CBUS_ARB_ROUND_ROBIN_EN defined: search SHALL start at (last_owner+1) mod NUM_INPUTS; last_owner is updated on each grant.
REQ-024 Macro CBUS_ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-015; no last_owner register.

Structure
REQ-025 cbus_req_t and cbus_resp_t SHALL come from shared package common; the arbiter state enum is local.
REQ-026 One combinational sub-module, cbus_arb_select, SHALL compute the winner from the valid vector and start pointer.

Verification
REQ-027 Only port 1 requests a read burst with len=MLEN16 -> grant after one cycle; 16 ready beats forwarded to iresps[1]; IDLE the cycle after last; iresps[0] stays 0.
REQ-028 Ports 0 and 1 request in the same cycle, fixed priority -> port 0 served first; port 1 granted one cycle after port 0's last.
REQ-029 Same as REQ-028 with CBUS_ARB_ROUND_ROBIN_EN, repeated three times -> grant order 0,1,0,1,0,1.
REQ-030 Port 1 uncached single write (len=MLEN1, strobe=8'h0F, addr=0x1000_0000) -> oreq mirrors the fields exactly; BUSY lasts until the single ready&last beat.
REQ-031 reset=0 driven mid-burst at beat 5 of 16 -> IDLE next cycle; oreq.valid=0; a new request is granted normally after reset releases.
REQ-032 Port 0 requests while port 1 owns the bus with oresp stalled (ready=0) for 10 cycles -> iresps[0] stays 0 throughout; no ownership change.
